// File: rtl/dcache_assoc.sv
// N-way set-associative write-back / write-allocate data cache with tree-PLRU
// replacement, alignment check and saturating hit/miss counters.
//
// state  | meaning
// IDLE   | serve hits; on a miss pick a victim and start the bus sequence
// WB     | dirty victim line is being written back (mem_srp held)
// FILL   | requested line is being fetched into the victim way (mem_ldp held)
module dcache_assoc #(
   parameter int PHY_LEN   = 20,
   parameter int ARCH_LEN  = 32,
   parameter int LINE_BITS = 128,
   parameter int SETS      = 4,
   parameter int WAYS      = 2,
   parameter int CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PHY_LEN-1:0]   addr,
   input  logic                 enable,
   input  logic                 we,
   input  logic [2:0]           width,
   input  logic [ARCH_LEN-1:0]  i_data,
   output logic [ARCH_LEN-1:0]  o_data,
   output logic                 miss,
   output logic                 evict,
   output logic                 unaligned,
   output logic [PHY_LEN-1:0]   mem_addr,
   output logic                 mem_ldp,
   input  logic                 mem_ldr,
   input  logic [LINE_BITS-1:0] mem_ld_data,
   output logic                 mem_srp,
   input  logic                 mem_srr,
   output logic [LINE_BITS-1:0] mem_sr_data,
   output logic [CNT_W-1:0]     hit_cnt,
   output logic [CNT_W-1:0]     miss_cnt
);
   localparam int OFF_W  = $clog2(LINE_BITS / 8);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = PHY_LEN - OFF_W - IDX_W;
   localparam int BO_W   = $clog2(ARCH_LEN / 8);
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int PL_W   = (WAYS > 1) ? WAYS - 1 : 1;
   localparam int LBYTES = LINE_BITS / 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WB   = 2'd1;
   localparam logic [1:0] S_FILL = 2'd2;

   logic [LINE_BITS-1:0] data_q [SETS][WAYS];
   logic [LINE_BITS-1:0] data_d [SETS][WAYS];
   logic [TAG_W-1:0]     tag_q  [SETS][WAYS];
   logic [TAG_W-1:0]     tag_d  [SETS][WAYS];
   logic [WAYS-1:0]      valid_q [SETS];
   logic [WAYS-1:0]      valid_d [SETS];
   logic [WAYS-1:0]      dirty_q [SETS];
   logic [WAYS-1:0]      dirty_d [SETS];
   logic [PL_W-1:0]      plru_q  [SETS];
   logic [PL_W-1:0]      plru_d  [SETS];
   logic [1:0]           state_q, state_d;
   logic [TAG_W+IDX_W-1:0] req_line_q, req_line_d;
   logic [WAY_W-1:0]     vic_q, vic_d;
   logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   logic [IDX_W-1:0]     idx, ridx;
   logic [TAG_W-1:0]     tag, rtag;
   logic                 is_b, is_h, misalign, hit_any;
   logic [WAY_W-1:0]     hit_way, vic_sel;
   logic [LINE_BITS-1:0] line_rd, line_wr;
   logic [ARCH_LEN-1:0]  word_rd, sh, ld_ext;
   logic                 miss_r, evict_r, ldp_r, srp_r;

   assign idx  = addr[OFF_W +: IDX_W];
   assign tag  = addr[PHY_LEN-1 -: TAG_W];
   assign ridx = req_line_q[IDX_W-1:0];
   assign rtag = req_line_q[TAG_W+IDX_W-1 -: TAG_W];

   // Tree bits: [0] picks the half to replace, [1]/[2] pick within the left/right pair.
   function automatic logic [WAY_W-1:0] plru_victim(input logic [PL_W-1:0] p);
      logic [2:0] t;
      t = 3'(p);
      if (WAYS == 4) return WAY_W'({t[0], t[0] ? t[2] : t[1]});
      else if (WAYS == 2) return WAY_W'(t[0]);
      return '0;
   endfunction

   function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] p, input logic [WAY_W-1:0] w);
      logic [2:0] t;
      logic [1:0] v;
      t = 3'(p);
      v = 2'(w);
      if (WAYS == 4) begin
         t[0] = ~v[1];
         if (v[1]) t[2] = ~v[0];
         else      t[1] = ~v[0];
      end else begin
         t[0] = ~v[0];
      end
      return PL_W'(t);
   endfunction

   always_comb begin
      is_b     = (width == 3'd0) || (width == 3'd4);
      is_h     = (width == 3'd1) || (width == 3'd5);
      misalign = (is_h && addr[0]) || (!is_b && !is_h && (addr[BO_W-1:0] != '0));
      hit_any  = 1'b0;
      hit_way  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
            hit_any = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
      vic_sel = plru_victim(plru_q[idx]);
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[idx][w]) vic_sel = WAY_W'(w);
      end
   end

   always_comb begin
      int boff;
      int nb;
      line_rd = data_q[idx][hit_way];
      word_rd = line_rd[int'(addr[OFF_W-1:BO_W]) * ARCH_LEN +: ARCH_LEN];
      sh      = word_rd >> {addr[BO_W-1:0], 3'b000};
      case (width)
         3'd0:    ld_ext = {{(ARCH_LEN-8){sh[7]}}, sh[7:0]};
         3'd1:    ld_ext = {{(ARCH_LEN-16){sh[15]}}, sh[15:0]};
         3'd4:    ld_ext = {{(ARCH_LEN-8){1'b0}}, sh[7:0]};
         3'd5:    ld_ext = {{(ARCH_LEN-16){1'b0}}, sh[15:0]};
         default: ld_ext = sh;
      endcase
      boff    = int'(addr[OFF_W-1:0]);
      nb      = is_b ? 1 : (is_h ? 2 : ARCH_LEN / 8);
      line_wr = line_rd;
      for (int k = 0; k < LBYTES; k++) begin
         if (k >= boff && k < boff + nb) line_wr[8*k +: 8] = i_data[8*(k-boff) +: 8];
      end
   end

   always_comb begin
      data_d      = data_q;
      tag_d       = tag_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      plru_d      = plru_q;
      state_d     = state_q;
      req_line_d  = req_line_q;
      vic_d       = vic_q;
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      miss_r      = 1'b0;
      evict_r     = 1'b0;
      ldp_r       = 1'b0;
      srp_r       = 1'b0;
      mem_addr    = '0;
      mem_sr_data = data_q[ridx][vic_q];
      case (state_q)
         S_IDLE: begin
            if (enable && !misalign) begin
               if (hit_any) begin
                  if (we) begin
                     data_d[idx][hit_way]  = line_wr;
                     dirty_d[idx][hit_way] = 1'b1;
                  end
                  plru_d[idx] = plru_touch(plru_q[idx], hit_way);
                  hit_cnt_d   = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + 1'b1;
               end else begin
                  miss_r      = 1'b1;
                  miss_cnt_d  = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 1'b1;
                  req_line_d  = {tag, idx};
                  vic_d       = vic_sel;
                  mem_sr_data = data_q[idx][vic_sel];
                  if (dirty_q[idx][vic_sel]) begin
                     state_d  = S_WB;
                     evict_r  = 1'b1;
                     srp_r    = 1'b1;
                     mem_addr = {tag_q[idx][vic_sel], idx, {OFF_W{1'b0}}};
                  end else begin
                     state_d  = S_FILL;
                     ldp_r    = 1'b1;
                     mem_addr = {tag, idx, {OFF_W{1'b0}}};
                  end
               end
            end
         end
         S_WB: begin
            miss_r   = 1'b1;
            evict_r  = 1'b1;
            srp_r    = 1'b1;
            mem_addr = {tag_q[ridx][vic_q], ridx, {OFF_W{1'b0}}};
            if (mem_srr) begin
               dirty_d[ridx][vic_q] = 1'b0;
               state_d              = S_FILL;
            end
         end
         S_FILL: begin
            miss_r   = 1'b1;
            ldp_r    = 1'b1;
            mem_addr = {rtag, ridx, {OFF_W{1'b0}}};
            if (mem_ldr) begin
               data_d[ridx][vic_q]  = mem_ld_data;
               tag_d[ridx][vic_q]   = rtag;
               valid_d[ridx][vic_q] = 1'b1;
               dirty_d[ridx][vic_q] = 1'b0;
               state_d              = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Reset wins over any FSM activity, so every visible control output is masked by rst.
   assign o_data    = rst ? '0 : ld_ext;
   assign miss      = miss_r & ~rst;
   assign evict     = evict_r & ~rst;
   assign unaligned = enable & misalign & ~rst;
   assign mem_ldp   = ldp_r & ~rst;
   assign mem_srp   = srp_r & ~rst;
   assign hit_cnt   = rst ? '0 : hit_cnt_q;
   assign miss_cnt  = rst ? '0 : miss_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         req_line_q <= '0;
         vic_q      <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         state_q    <= state_d;
         req_line_q <= req_line_d;
         vic_q      <= vic_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         valid_q    <= valid_d;
         dirty_q    <= dirty_d;
         plru_q     <= plru_d;
      end
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
      tag_q  <= tag_d;
   end
endmodule

// File: tb/tb_dcache_assoc.sv
// Scenario bench for dcache_assoc: line-level memory responder, reference byte
// model of architectural memory, and a queue of expected load results.
module tb_dcache_assoc;
   logic         clk, rst, enable, we, mem_ldr, mem_srr;
   logic [19:0]  addr, mem_addr;
   logic [2:0]   width;
   logic [31:0]  i_data, o_data;
   logic         miss, evict, unaligned, mem_ldp, mem_srp;
   logic [127:0] mem_ld_data, mem_sr_data;
   logic [31:0]  hit_cnt, miss_cnt;

   int checks = 0;
   int errors = 0;
   logic [31:0]  exp_q[$];
   logic [127:0] bmem [logic [19:0]];
   logic [127:0] rmem [logic [19:0]];

   dcache_assoc dut (
      .clk(clk), .rst(rst), .addr(addr), .enable(enable), .we(we), .width(width),
      .i_data(i_data), .o_data(o_data), .miss(miss), .evict(evict), .unaligned(unaligned),
      .mem_addr(mem_addr), .mem_ldp(mem_ldp), .mem_ldr(mem_ldr), .mem_ld_data(mem_ld_data),
      .mem_srp(mem_srp), .mem_srr(mem_srr), .mem_sr_data(mem_sr_data),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] init_line(input logic [19:0] la);
      logic [127:0] l;
      for (int i = 0; i < 4; i++)
         l[32*i +: 32] = ((32'(la) ^ 32'h100) * 32'h0100_0193) ^ 32'hDEAD_BEEF ^ (32'(i) * 32'h1111_1111);
      return l;
   endfunction

   function automatic logic [127:0] bline(input logic [19:0] la);
      return bmem.exists(la) ? bmem[la] : init_line(la);
   endfunction

   function automatic logic [127:0] rline(input logic [19:0] la);
      return rmem.exists(la) ? rmem[la] : init_line(la);
   endfunction

   function automatic logic [31:0] ref_load(input logic [19:0] a, input logic [2:0] wd);
      logic [127:0] l;
      logic [31:0]  wv, s;
      l  = rline({a[19:4], 4'h0});
      wv = l[32*a[3:2] +: 32];
      s  = wv >> (8*a[1:0]);
      case (wd)
         3'd0:    return {{24{s[7]}}, s[7:0]};
         3'd1:    return {{16{s[15]}}, s[15:0]};
         3'd4:    return {24'h0, s[7:0]};
         3'd5:    return {16'h0, s[15:0]};
         default: return s;
      endcase
   endfunction

   task automatic ref_store(input logic [19:0] a, input logic [2:0] wd, input logic [31:0] d);
      logic [127:0] l;
      int nb;
      l  = rline({a[19:4], 4'h0});
      nb = (wd == 3'd0 || wd == 3'd4) ? 1 : ((wd == 3'd1 || wd == 3'd5) ? 2 : 4);
      for (int k = 0; k < nb; k++) l[8*(int'(a[3:0]) + k) +: 8] = d[8*k +: 8];
      rmem[{a[19:4], 4'h0}] = l;
   endtask

   // Called on a negedge; returns on the negedge after the access completed.
   task automatic access(input logic [19:0] a, input logic w_e, input logic [2:0] wd, input logic [31:0] d,
                         output int mcyc, output logic [31:0] rdat, output logic wb_seen,
                         output logic [19:0] wb_addr, output logic [19:0] fill_addr, output logic bus_bad);
      int srw, ldw;
      logic done, srr_sent, srr_just;
      logic [31:0] exp;
      addr = a; we = w_e; width = wd; i_data = d; enable = 1'b1;
      if (!w_e) exp_q.push_back(ref_load(a, wd));
      else ref_store(a, wd, d);
      mcyc = 0; srw = 0; ldw = 0; wb_seen = 0; bus_bad = 0; done = 0; rdat = '0;
      wb_addr = '0; fill_addr = '0; srr_sent = 0; srr_just = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         #1;
         if (!miss) begin
            done = 1'b1;
            rdat = o_data;
            if (mem_ldp || mem_srp) bus_bad = 1'b1;
            if (!w_e) begin
               exp = exp_q.pop_front();
               checks++;
               if (o_data !== exp) begin
                  errors++;
                  $display("FAIL load_data addr=%h width=%0d: got %h want %h", a, wd, o_data, exp);
               end
            end
         end else begin
            mcyc++;
            if (!(mem_ldp ^ mem_srp)) bus_bad = 1'b1;
            if (srr_just && !mem_ldp) bus_bad = 1'b1;
            srr_just = 1'b0;
            if (mem_srp) begin
               wb_seen = 1'b1;
               wb_addr = mem_addr;
               srw++;
               if (srw == 2) begin
                  checks++;
                  if (mem_sr_data !== rline(mem_addr)) begin
                     errors++;
                     $display("FAIL wb_data addr=%h: got %h want %h", mem_addr, mem_sr_data, rline(mem_addr));
                  end
                  bmem[mem_addr] = mem_sr_data;
                  mem_srr  = 1'b1;
                  srr_sent = 1'b1;
                  srr_just = 1'b1;
               end
            end
            if (mem_ldp) begin
               if (wb_seen && !srr_sent) bus_bad = 1'b1;
               fill_addr = mem_addr;
               ldw++;
               if (ldw == 3) begin
                  mem_ld_data = bline(mem_addr);
                  mem_ldr     = 1'b1;
               end
            end
         end
         @(negedge clk);
         mem_srr = 1'b0;
         mem_ldr = 1'b0;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL access_timeout addr=%h: got miss=%b want completion", a, miss);
         if (!w_e) void'(exp_q.pop_front());
      end
      enable = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; mem_ldr = 1'b0; mem_srr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      rmem = bmem;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b1; we = 1'b0; width = 3'd2; addr = 20'h00100; i_data = '0;
      mem_ldr = 1'b0; mem_srr = 1'b0; mem_ld_data = '0;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if ({o_data, miss, evict, unaligned, mem_ldp, mem_srp} !== 37'h0 || hit_cnt !== 0 || miss_cnt !== 0) begin
         errors++;
         $display("FAIL reset_outputs: got o=%h m=%b e=%b u=%b ldp=%b srp=%b h=%0d mc=%0d want all 0",
                  o_data, miss, evict, unaligned, mem_ldp, mem_srp, hit_cnt, miss_cnt);
      end
      @(negedge clk);
      rst = 1'b0; enable = 1'b0;
      rmem = bmem;
   endtask

   task automatic test_cold_load();
      int mc; logic [31:0] rd; logic wbs, bb; logic [19:0] wba, fa;
      access(20'h00100, 1'b0, 3'd2, 32'h0, mc, rd, wbs, wba, fa, bb);
      checks++;
      if (mc != 3 || fa !== 20'h00100 || wbs !== 1'b0 || bb !== 1'b0) begin
         errors++;
         $display("FAIL cold_miss: got cyc=%0d fill=%h wb=%b bad=%b want 3 00100 0 0", mc, fa, wbs, bb);
      end
      checks++;
      if (rd !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL cold_data: got %h want deadbeef", rd);
      end
      #1;
      checks++;
      if (miss_cnt !== 32'd1 || hit_cnt !== 32'd1) begin
         errors++;
         $display("FAIL cold_counters: got miss=%0d hit=%0d want 1 1", miss_cnt, hit_cnt);
      end
   endtask

   task automatic test_byte_ext();
      int mc; logic [31:0] rd; logic wbs, bb; logic [19:0] wba, fa;
      access(20'h00101, 1'b1, 3'd0, 32'h0000_0080, mc, rd, wbs, wba, fa, bb);
      checks++;
      if (mc != 0 || bb !== 1'b0) begin
         errors++;
         $display("FAIL store_hit: got cyc=%0d bad=%b want 0 0", mc, bb);
      end
      access(20'h00101, 1'b0, 3'd0, 32'h0, mc, rd, wbs, wba, fa, bb);
      checks++;
      if (rd !== 32'hFFFF_FF80) begin
         errors++;
         $display("FAIL load_b: got %h want ffffff80", rd);
      end
      access(20'h00101, 1'b0, 3'd4, 32'h0, mc, rd, wbs, wba, fa, bb);
      checks++;
      if (rd !== 32'h0000_0080) begin
         errors++;
         $display("FAIL load_bu: got %h want 00000080", rd);
      end
      access(20'h00100, 1'b0, 3'd1, 32'h0, mc, rd, wbs, wba, fa, bb);
      access(20'h0010E, 1'b0, 3'd5, 32'h0, mc, rd, wbs, wba, fa, bb);
   endtask

   task automatic test_conflict();
      int mc; logic [31:0] rd; logic wbs, bb; logic [19:0] wba, fa;
      do_reset();
      access(20'h00000, 1'b0, 3'd2, 32'h0, mc, rd, wbs, wba, fa, bb);
      access(20'h00040, 1'b0, 3'd2, 32'h0, mc, rd, wbs, wba, fa, bb);
      access(20'h00004, 1'b0, 3'd2, 32'h0, mc, rd, wbs, wba, fa, bb);
      checks++;
      if (mc != 0) begin errors++; $display("FAIL touch_hit: got cyc=%0d want 0", mc); end
      access(20'h00080, 1'b0, 3'd2, 32'h0, mc, rd, wbs, wba, fa, bb);
      checks++;
      if (mc != 3 || wbs !== 1'b0 || fa !== 20'h00080) begin
         errors++;
         $display("FAIL conflict_fill: got cyc=%0d wb=%b fill=%h want 3 0 00080", mc, wbs, fa);
      end
      access(20'h00008, 1'b0, 3'd2, 32'h0, mc, rd, wbs, wba, fa, bb);
      checks++;
      if (mc != 0) begin errors++; $display("FAIL mru_kept: got cyc=%0d want 0", mc); end
      access(20'h00040, 1'b0, 3'd2, 32'h0, mc, rd, wbs, wba, fa, bb);
      checks++;
      if (mc == 0) begin errors++; $display("FAIL lru_replaced: got cyc=%0d want >0", mc); end
   endtask

   task automatic test_dirty_evict();
      int mc; logic [31:0] rd; logic wbs, bb; logic [19:0] wba, fa;
      do_reset();
      access(20'h00000, 1'b1, 3'd2, 32'h1111_2222, mc, rd, wbs, wba, fa, bb);
      access(20'h00044, 1'b1, 3'd2, 32'h3333_4444, mc, rd, wbs, wba, fa, bb);
      access(20'h000C0, 1'b0, 3'd2, 32'h0, mc, rd, wbs, wba, fa, bb);
      checks++;
      if (wbs !== 1'b1 || wba !== 20'h00000 || mc != 5 || bb !== 1'b0 || fa !== 20'h000C0) begin
         errors++;
         $display("FAIL evict_seq: got wb=%b wbaddr=%h cyc=%0d bad=%b fill=%h want 1 00000 5 0 000c0",
                  wbs, wba, mc, bb, fa);
      end
      access(20'h00080, 1'b0, 3'd2, 32'h0, mc, rd, wbs, wba, fa, bb);
      checks++;
      if (wbs !== 1'b1 || wba !== 20'h00040) begin
         errors++;
         $display("FAIL evict_second: got wb=%b wbaddr=%h want 1 00040", wbs, wba);
      end
      access(20'h00000, 1'b0, 3'd2, 32'h0, mc, rd, wbs, wba, fa, bb);
      checks++;
      if (wbs !== 1'b0 || rd !== 32'h1111_2222) begin
         errors++;
         $display("FAIL clean_victim: got wb=%b data=%h want 0 11112222", wbs, rd);
      end
   endtask

   task automatic test_unaligned();
      do_reset();
      addr = 20'h00102; we = 1'b0; width = 3'd2; enable = 1'b1;
      #1;
      checks++;
      if (unaligned !== 1'b1 || miss !== 1'b0 || mem_ldp !== 1'b0 || mem_srp !== 1'b0) begin
         errors++;
         $display("FAIL unaligned_w: got u=%b m=%b ldp=%b srp=%b want 1 0 0 0", unaligned, miss, mem_ldp, mem_srp);
      end
      @(negedge clk);
      addr = 20'h00103; width = 3'd1;
      #1;
      checks++;
      if (unaligned !== 1'b1 || miss !== 1'b0 || mem_ldp !== 1'b0 || mem_srp !== 1'b0) begin
         errors++;
         $display("FAIL unaligned_h: got u=%b m=%b ldp=%b srp=%b want 1 0 0 0", unaligned, miss, mem_ldp, mem_srp);
      end
      @(negedge clk);
      enable = 1'b0;
      #1;
      checks++;
      if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
         errors++;
         $display("FAIL unaligned_cnt: got hit=%0d miss=%0d want 0 0", hit_cnt, miss_cnt);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_fill();
      int mc; logic [31:0] rd; logic wbs, bb; logic [19:0] wba, fa;
      do_reset();
      addr = 20'h00200; we = 1'b0; width = 3'd2; enable = 1'b1;
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (mem_ldp !== 1'b0 || miss !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_fill: got ldp=%b miss=%b want 0 0", mem_ldp, miss);
      end
      @(negedge clk);
      rst = 1'b0; enable = 1'b0;
      mem_ld_data = ~bline(20'h00200);
      mem_ldr = 1'b1;
      #1;
      checks++;
      if (mem_ldp !== 1'b0 || miss !== 1'b0) begin
         errors++;
         $display("FAIL stray_pulse: got ldp=%b miss=%b want 0 0", mem_ldp, miss);
      end
      @(negedge clk);
      mem_ldr = 1'b0;
      access(20'h00200, 1'b0, 3'd2, 32'h0, mc, rd, wbs, wba, fa, bb);
      checks++;
      if (mc != 3 || fa !== 20'h00200) begin
         errors++;
         $display("FAIL post_reset_miss: got cyc=%0d fill=%h want 3 00200", mc, fa);
      end
   endtask

   task automatic test_back_to_back();
      int mc, nmiss, ndone, nbad;
      logic [31:0] rd; logic wbs, bb; logic [19:0] wba, fa, a;
      logic [2:0] wl [5];
      logic [2:0] wd;
      logic st;
      wl = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      do_reset();
      nmiss = 0; ndone = 0; nbad = 0;
      for (int n = 0; n < 60; n++) begin
         st = 1'($urandom_range(0, 1));
         wd = st ? wl[$urandom_range(0, 2)] : wl[$urandom_range(0, 4)];
         a  = 20'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
         if (wd == 3'd1 || wd == 3'd5) a[0] = 1'b0;
         if (wd == 3'd2) a[1:0] = 2'b00;
         access(a, st, wd, $urandom, mc, rd, wbs, wba, fa, bb);
         if (mc > 0) nmiss++;
         ndone++;
         if (bb) nbad++;
      end
      #1;
      checks++;
      if (nbad != 0) begin errors++; $display("FAIL b2b_bus: got %0d bad accesses want 0", nbad); end
      checks++;
      if (hit_cnt !== 32'(ndone) || miss_cnt !== 32'(nmiss)) begin
         errors++;
         $display("FAIL b2b_counters: got hit=%0d miss=%0d want %0d %0d", hit_cnt, miss_cnt, ndone, nmiss);
      end
   endtask

   initial begin
      test_reset();
      test_cold_load();
      test_byte_ext();
      test_conflict();
      test_dirty_evict();
      test_unaligned();
      test_reset_fill();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
